// File: rtl/pcs_tx_oset_ctrl_if.sv
// GMII transmit and encoder-side signal bundle for pcs_tx_oset_ctrl.
// The master drives GMII and the encoder acknowledge; the slave is the ordered-set controller.
interface pcs_tx_oset_ctrl_if;
  logic       TX_EN;
  logic       TX_ER;
  logic [7:0] TXD;
  logic       receiving;
  logic       tx_oset_indicate;
  logic [7:0] tx_o_set;
  logic       tx_even;
  logic       transmitting;
  logic       COL;

  modport master (
    output TX_EN, TX_ER, TXD, receiving, tx_oset_indicate,
    input  tx_o_set, tx_even, transmitting, COL
  );

  modport slave (
    input  TX_EN, TX_ER, TXD, receiving, tx_oset_indicate,
    output tx_o_set, tx_even, transmitting, COL
  );
endinterface

// File: rtl/pcs_tx_oset_ctrl.sv
// PCS transmit ordered-set process: GMII TX_EN/TX_ER/TXD to /I/ /S/ data /V/ /T/ /R/ octets.
// Define PCS_TX_CNT_EN to add saturating /T/ and /V/ statistics counters.
module pcs_tx_oset_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              GTX_CLK,
  input  logic              RESET,
  pcs_tx_oset_ctrl_if.slave bus
`ifdef PCS_TX_CNT_EN
  ,
  output logic [CNT_W-1:0]  tx_pkt_cnt,
  output logic [CNT_W-1:0]  tx_err_cnt
`endif
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;

  typedef enum logic [3:0] {
    IDLE_K, IDLE_D, SOP, PKT, ERR, EOP_T, EPD_R1, CEXT, EPD_R2
  } state_t;

  state_t     state;
  logic [7:0] oset;
  logic       even;
  logic       xmit;
  logic       col;

  always_ff @(posedge GTX_CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE_K;
      oset  <= K28_5;
      even  <= 1'b1;
      xmit  <= 1'b0;
      col   <= 1'b0;
`ifdef PCS_TX_CNT_EN
      tx_pkt_cnt <= '0;
      tx_err_cnt <= '0;
`endif
    end else begin
      col <= xmit & bus.receiving;
      if (bus.tx_oset_indicate) begin
        even <= ~even;
        case (state)
          IDLE_K: begin
            state <= IDLE_D;
            oset  <= D16_2;
          end
          IDLE_D: begin
            if (bus.TX_EN) begin
              state <= SOP;
              oset  <= K27_7;
              xmit  <= 1'b1;
            end else begin
              state <= IDLE_K;
              oset  <= K28_5;
              even  <= 1'b1;
            end
          end
          SOP, PKT, ERR: begin
            if (!bus.TX_EN) begin
              state <= EOP_T;
              oset  <= K29_7;
`ifdef PCS_TX_CNT_EN
              if (tx_pkt_cnt != '1) tx_pkt_cnt <= tx_pkt_cnt + CNT_W'(1);
`endif
            end else if (bus.TX_ER) begin
              state <= ERR;
              oset  <= K30_7;
`ifdef PCS_TX_CNT_EN
              if (tx_err_cnt != '1) tx_err_cnt <= tx_err_cnt + CNT_W'(1);
`endif
            end else begin
              state <= PKT;
              oset  <= bus.TXD;
            end
          end
          EOP_T: begin
            state <= EPD_R1;
            oset  <= K23_7;
            xmit  <= 1'b0;
          end
          EPD_R1, CEXT: begin
            // Extension is entered only from R1 with TX_EN low, but held on TX_ER alone.
            // Leaving from an odd slot goes straight to idle, otherwise a second /R/ pads it.
            if ((state == CEXT) ? bus.TX_ER : (!bus.TX_EN && bus.TX_ER)) begin
              state <= CEXT;
              oset  <= K23_7;
            end else if (even) begin
              state <= EPD_R2;
              oset  <= K23_7;
            end else begin
              state <= IDLE_K;
              oset  <= K28_5;
              even  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE_K;
            oset  <= K28_5;
            even  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.tx_o_set     = oset;
  assign bus.tx_even      = even;
  assign bus.transmitting = xmit;
  assign bus.COL          = col;

endmodule
